// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared mode and direction encodings for the sweep generator
package sweep_pkg;

  localparam logic [1:0] MODE_SAW     = 2'd0;
  localparam logic [1:0] MODE_TRI     = 2'd1;
  localparam logic [1:0] MODE_HOLD    = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/sweep_channel.sv
// rtl/sweep_channel.sv - one sweep channel: fixed-point accumulator, direction, done flag, mode logic
module sweep_channel
  import sweep_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     on_i,
  input  logic                     sync_i,
  input  logic                     tick_i,
  input  logic [1:0]               mode_i,
  input  logic signed [WIDTH-1:0]  min_i,
  input  logic signed [WIDTH-1:0]  max_i,
  input  logic [WIDTH+FRAC-1:0]    step_i,
  output logic signed [WIDTH-1:0]  sample_o,
  output logic                     wrap_o,
  output logic                     done_o
);

  localparam int AW = WIDTH + FRAC;
  // Two guard bits keep acc+step and acc-step exact for any unsigned step.
  localparam int CW = AW + 2;

  logic signed [AW-1:0] acc_q, acc_d;
  dir_e                 dir_q, dir_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;

  logic signed [AW-1:0] min_a, max_a;
  logic signed [CW-1:0] acc_x, min_x, max_x, step_x, up_x, dn_x;

  assign min_a  = {min_i, {FRAC{1'b0}}};
  assign max_a  = {max_i, {FRAC{1'b0}}};
  assign min_x  = {{2{min_i[WIDTH-1]}}, min_i, {FRAC{1'b0}}};
  assign max_x  = {{2{max_i[WIDTH-1]}}, max_i, {FRAC{1'b0}}};
  assign acc_x  = {{2{acc_q[AW-1]}}, acc_q};
  assign step_x = {2'b00, step_i};
  assign up_x   = acc_x + step_x;
  assign dn_x   = acc_x - step_x;

  always_comb begin
    acc_d  = acc_q;
    dir_d  = dir_q;
    done_d = done_q;
    wrap_d = 1'b0;
    if (!on_i || sync_i) begin
      acc_d  = min_a;
      dir_d  = DIR_UP;
      done_d = 1'b0;
    end else if (min_i >= max_i) begin
      acc_d = min_a;
    end else if (tick_i && !done_q && (step_i != '0)) begin
      case (mode_i)
        MODE_SAW: begin
          if (up_x > max_x) begin
            acc_d  = min_a;
            wrap_d = 1'b1;
          end else begin
            acc_d = up_x[AW-1:0];
          end
        end
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (up_x >= max_x) begin
              acc_d = max_a;
              dir_d = DIR_DN;
            end else begin
              acc_d = up_x[AW-1:0];
            end
          end else begin
            if (dn_x <= min_x) begin
              acc_d  = min_a;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              acc_d = dn_x[AW-1:0];
            end
          end
        end
        MODE_HOLD: begin
          acc_d = min_a;
        end
        MODE_ONESHOT: begin
          if (up_x >= max_x) begin
            acc_d  = max_a;
            done_d = 1'b1;
            wrap_d = 1'b1;
          end else begin
            acc_d = up_x[AW-1:0];
          end
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      dir_q  <= DIR_UP;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign sample_o = acc_q[AW-1 -: WIDTH];
  assign wrap_o   = wrap_q;
  assign done_o   = done_q;

endmodule

// File: rtl/sweep_gen_multi.sv
// rtl/sweep_gen_multi.sv - multi-channel ramp/waveform generator: shared prescaler plus NCH channels
module sweep_gen_multi
  import sweep_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 16,
  parameter int FRAC  = 16,
  parameter int PRE_W = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NCH-1:0]              on_in,
  input  logic                        sync_in,
  input  logic [PRE_W-1:0]            prescale_in,
  input  logic [2*NCH-1:0]            mode_in,
  input  logic [WIDTH*NCH-1:0]        minval_in,
  input  logic [WIDTH*NCH-1:0]        maxval_in,
  input  logic [(WIDTH+FRAC)*NCH-1:0] stepsize_in,
  output logic [WIDTH*NCH-1:0]        signal_out,
  output logic                        tick_out,
  output logic [NCH-1:0]              wrap_out,
  output logic [NCH-1:0]              done_out
);

  localparam int AW = WIDTH + FRAC;

  logic [PRE_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // A prescale lowered below the count only matches again after the counter wraps.
  always_comb begin
    count_d = count_q + PRE_W'(1);
    tick_d  = 1'b0;
    if (sync_in) begin
      count_d = '0;
    end else if (count_q == prescale_in) begin
      count_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_out = tick_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sweep_channel #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_ch (
      .clk_i    (clk_in),
      .rst_ni   (rst_n_in),
      .on_i     (on_in[c]),
      .sync_i   (sync_in),
      .tick_i   (tick_d),
      .mode_i   (mode_in[2*c +: 2]),
      .min_i    (minval_in[c*WIDTH +: WIDTH]),
      .max_i    (maxval_in[c*WIDTH +: WIDTH]),
      .step_i   (stepsize_in[c*AW +: AW]),
      .sample_o (signal_out[c*WIDTH +: WIDTH]),
      .wrap_o   (wrap_out[c]),
      .done_o   (done_out[c])
    );
  end

endmodule

// File: tb/tb_sweep_gen_multi.sv
// tb/tb_sweep_gen_multi.sv - directed scoreboard bench for sweep_gen_multi
module tb_sweep_gen_multi;
  import sweep_pkg::*;

  localparam int K_SIG0  = 0;
  localparam int K_SIG1  = 1;
  localparam int K_WRAP0 = 2;
  localparam int K_WRAP1 = 3;
  localparam int K_DONE  = 4;
  localparam int K_TICK  = 5;

  typedef struct {
    int                 kind;
    logic signed [15:0] exp;
    string              tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  on;
  logic        sync;
  logic [7:0]  prescale;
  logic [3:0]  mode;
  logic [31:0] minval;
  logic [31:0] maxval;
  logic [63:0] stepsize;
  logic [31:0] signal_out;
  logic        tick_out;
  logic [1:0]  wrap_out;
  logic [1:0]  done_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int saw_exp[11] = '{-3, -2, -1, 0, 1, 2, 3, -4, -3, -2, -1};
  int tri_exp[11] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3, 6};

  sweep_gen_multi #(.NCH(2), .WIDTH(16), .FRAC(16), .PRE_W(8)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .on_in       (on),
    .sync_in     (sync),
    .prescale_in (prescale),
    .mode_in     (mode),
    .minval_in   (minval),
    .maxval_in   (maxval),
    .stepsize_in (stepsize),
    .signal_out  (signal_out),
    .tick_out    (tick_out),
    .wrap_out    (wrap_out),
    .done_out    (done_out)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] observe(int kind);
    case (kind)
      K_SIG0:  return signal_out[15:0];
      K_SIG1:  return signal_out[31:16];
      K_WRAP0: return {15'd0, wrap_out[0]};
      K_WRAP1: return {15'd0, wrap_out[1]};
      K_DONE:  return {14'd0, done_out};
      default: return {15'd0, tick_out};
    endcase
  endfunction

  function automatic void push(int kind, int val, string tag);
    exp_t e;
    e.kind = kind;
    e.exp  = 16'(val);
    e.tag  = tag;
    sb.push_back(e);
  endfunction

  task automatic drain();
    exp_t e;
    logic signed [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic set_ch(int c, int mn, int mx, logic [31:0] st, logic [1:0] md);
    minval[c*16 +: 16]   = 16'(mn);
    maxval[c*16 +: 16]   = 16'(mx);
    stepsize[c*32 +: 32] = st;
    mode[c*2 +: 2]       = md;
  endtask

  initial begin
    rst_n = 1'b0; on = 2'b00; sync = 1'b0; prescale = 8'd0;
    mode = '0; minval = '0; maxval = '0; stepsize = '0;
    set_ch(0, -4, 3, 32'h0001_0000, MODE_SAW);
    set_ch(1, 0, 10, 32'h0003_0000, MODE_TRI);
    step();
    push(K_SIG0, 0, "rst_sig0"); push(K_SIG1, 0, "rst_sig1");
    push(K_WRAP0, 0, "rst_wrap0"); push(K_WRAP1, 0, "rst_wrap1");
    push(K_DONE, 0, "rst_done"); push(K_TICK, 0, "rst_tick");
    step();

    rst_n = 1'b1;
    push(K_SIG0, -4, "off_min0"); push(K_SIG1, 0, "off_min1");
    step();

    on = 2'b01;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) on = 2'b11;
      push(K_SIG0, saw_exp[k], "saw_ch0");
      push(K_SIG1, tri_exp[k], "tri_ch1");
      push(K_WRAP0, (k == 7) ? 1 : 0, "saw_wrap0");
      push(K_WRAP1, (k == 8) ? 1 : 0, "tri_wrap1");
      push(K_TICK, 1, "tick_pre0");
      step();
    end

    sync = 1'b1; prescale = 8'd3;
    push(K_SIG0, -4, "pre_sync_sig0"); push(K_TICK, 0, "pre_sync_tick");
    step();
    sync = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      push(K_TICK, (j % 4 == 0) ? 1 : 0, "pre3_tick");
      push(K_SIG0, -4 + j / 4, "pre3_sig0");
      step();
    end

    prescale = 8'd0;
    set_ch(0, -2, 2, 32'h0001_0000, MODE_ONESHOT);
    sync = 1'b1;
    push(K_SIG0, -2, "os_start"); push(K_DONE, 0, "os_start_done");
    step();
    sync = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      push(K_SIG0, (k < 4) ? -2 + k : 2, "os_sig0");
      push(K_DONE, (k >= 4) ? 1 : 0, "os_done");
      push(K_WRAP0, (k == 4) ? 1 : 0, "os_wrap0");
      step();
    end
    sync = 1'b1;
    push(K_SIG0, -2, "os_resync"); push(K_DONE, 0, "os_resync_done");
    step();
    sync = 1'b0;

    set_ch(0, 5, 5, 32'h0001_0000, MODE_SAW);
    for (int k = 0; k < 4; k++) begin
      push(K_SIG0, 5, "eq_sig0"); push(K_WRAP0, 0, "eq_wrap0");
      step();
    end

    set_ch(0, -4, 3, 32'h0001_0000, MODE_SAW);
    sync = 1'b1;
    push(K_SIG0, -4, "st0_sync");
    step();
    sync = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push(K_SIG0, -4 + k, "st0_ramp");
      step();
    end
    stepsize[31:0] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      push(K_SIG0, -1, "st0_hold"); push(K_WRAP0, 0, "st0_wrap0");
      step();
    end

    set_ch(0, -32768, 32767, 32'hFFFF_FFFF, MODE_SAW);
    sync = 1'b1;
    push(K_SIG0, -32768, "sat_sync");
    step();
    sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(K_SIG0, -32768, "sat_saw"); push(K_WRAP0, 1, "sat_saw_wrap");
      step();
    end
    mode[1:0] = MODE_TRI;
    sync = 1'b1;
    push(K_SIG0, -32768, "sat_tri_sync");
    step();
    sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(K_SIG0, (k % 2 == 0) ? 32767 : -32768, "sat_tri");
      push(K_WRAP0, (k % 2 == 1) ? 1 : 0, "sat_tri_wrap");
      step();
    end

    set_ch(0, -4, 3, 32'h0001_0000, MODE_SAW);
    set_ch(1, 0, 10, 32'h0003_0000, MODE_TRI);
    sync = 1'b1;
    push(K_SIG1, 0, "mid_sync1");
    step();
    sync = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(K_SIG1, tri_exp[k], "mid_tri1");
      step();
    end
    rst_n = 1'b0;
    push(K_SIG0, 0, "midrst_sig0"); push(K_SIG1, 0, "midrst_sig1");
    push(K_WRAP0, 0, "midrst_wrap0"); push(K_WRAP1, 0, "midrst_wrap1");
    push(K_DONE, 0, "midrst_done"); push(K_TICK, 0, "midrst_tick");
    step();
    rst_n = 1'b1; on = 2'b00;
    push(K_SIG0, -4, "off_sig0"); push(K_SIG1, 0, "off_sig1");
    step();
    on = 2'b11;
    push(K_SIG0, -3, "reon_sig0"); push(K_SIG1, 3, "reon_sig1");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
